// File: rtl/fir_bank_engine_if.sv
// Signal bundle between the audio source, the coefficient lookup and the shared-MAC FIR engine.
// The engine takes the slave view; the source/lookup side takes the master view.
interface fir_bank_engine_if #(
   parameter int DATA_W  = 8,
   parameter int COEFF_W = 10,
   parameter int TAPS    = 31,
   parameter int MODE_W  = 2
);
   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   logic        [MODE_W-1:0]  mode;
   logic                      ready;
   logic signed [DATA_W-1:0]  audio_in;
   logic        [MODE_W-1:0]  coeff_mode;
   logic        [IDX_W-1:0]   coeff_idx;
   logic signed [COEFF_W-1:0] coeff;
   logic signed [DATA_W-1:0]  audio_out;
   logic                      done;
   logic                      busy;
   logic        [MODE_W-1:0]  active_mode;
   logic                      overrun;
   logic                      overrun_clr;

   modport slave (
      input  mode, ready, audio_in, coeff, overrun_clr,
      output coeff_mode, coeff_idx, audio_out, done, busy, active_mode, overrun
   );

   modport master (
      output mode, ready, audio_in, coeff, overrun_clr,
      input  coeff_mode, coeff_idx, audio_out, done, busy, active_mode, overrun
   );
endinterface

// File: rtl/fir_bank_engine.sv
// Multi-bank FIR filter built around one time-multiplexed MAC; one output per TAPS+1 cycles.
// i_reset is synchronous and active-low.
module fir_bank_engine #(
   parameter int DATA_W          = 8,
   parameter int COEFF_W         = 10,
   parameter int TAPS            = 31,
   parameter int NUM_MODES       = 4,
   parameter int MODE_W          = 2,
   parameter int ACC_W           = 24,
   parameter int OUT_SHIFT       = 10,
   parameter int CLEAR_ON_SWITCH = 1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   fir_bank_engine_if.slave bus
);
   localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int PROD_W = DATA_W + COEFF_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
   localparam logic [IDX_W-1:0] TAPS_IDX = IDX_W'(TAPS);
   localparam logic signed [ACC_W:0] RND =
      (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (DATA_W - 1)));

   if (NUM_MODES > (1 << MODE_W)) begin : g_bad_modes
      $error("NUM_MODES does not fit in MODE_W bits");
   end
   if (ACC_W < PROD_W + IDX_W) begin : g_bad_acc
      $error("ACC_W too narrow for TAPS full-precision products");
   end

   function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      t = $signed({a[ACC_W-1], a}) + RND;
      return t >>> OUT_SHIFT;
   endfunction

   function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W:0] v);
      if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      else                  return v[DATA_W-1:0];
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_MAC, S_OUT} state_t;

   state_t                    r_state;
   logic signed [DATA_W-1:0]  r_hist [TAPS];
   logic        [IDX_W-1:0]   r_wr_ptr;
   logic        [IDX_W-1:0]   r_idx;
   logic        [IDX_W-1:0]   r_clr_idx;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [DATA_W-1:0]  r_hold;
   logic signed [DATA_W-1:0]  r_audio_out;
   logic                      r_done;
   logic                      r_busy;
   logic                      r_overrun;
   logic        [MODE_W-1:0]  r_active_mode;

   logic        [IDX_W-1:0]   w_rd_idx;
   logic        [IDX_W-1:0]   w_wr_ptr_nxt;
   logic signed [DATA_W-1:0]  w_hist_rd;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_acc_nxt;
   logic                      w_accept;

   // Tap i reads the sample written i accepts ago: hist[(wr_ptr - i) mod TAPS].
   always_comb begin
      w_rd_idx = '0;
      if (r_wr_ptr >= r_idx) w_rd_idx = r_wr_ptr - r_idx;
      else                   w_rd_idx = r_wr_ptr + TAPS_IDX - r_idx;
   end

   assign w_hist_rd    = r_hist[w_rd_idx];
   assign w_prod       = bus.coeff * w_hist_rd;
   assign w_acc_nxt    = r_acc + $signed({{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod});
   assign w_wr_ptr_nxt = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
   assign w_accept     = bus.ready & ~r_busy;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_idx         <= '0;
         r_clr_idx     <= '0;
         r_acc         <= '0;
         r_audio_out   <= '0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
         r_active_mode <= '0;
         for (int t = 0; t < TAPS; t++) r_hist[t] <= '0;
      end else begin
         r_done <= 1'b0;

         // A set in the same cycle as a clear wins.
         if (bus.ready && r_busy)  r_overrun <= 1'b1;
         else if (bus.overrun_clr) r_overrun <= 1'b0;

         case (r_state)
            S_IDLE, S_OUT: begin
               if (w_accept) begin
                  r_active_mode <= bus.mode;
                  r_busy        <= 1'b1;
                  if (CLEAR_ON_SWITCH != 0 && bus.mode != r_active_mode) begin
                     r_hold    <= bus.audio_in;
                     r_clr_idx <= '0;
                     r_state   <= S_CLEAR;
                  end else begin
                     r_hist[r_wr_ptr] <= bus.audio_in;
                     r_acc            <= '0;
                     r_idx            <= '0;
                     r_state          <= S_MAC;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CLEAR: begin
               r_hist[r_clr_idx] <= '0;
               if (r_clr_idx == LAST_IDX) begin
                  // Later assignment wins when wr_ptr is the last entry being zeroed.
                  r_hist[r_wr_ptr] <= r_hold;
                  r_acc            <= '0;
                  r_idx            <= '0;
                  r_state          <= S_MAC;
               end else begin
                  r_clr_idx <= r_clr_idx + 1'b1;
               end
            end
            S_MAC: begin
               r_acc <= w_acc_nxt;
               if (r_idx == LAST_IDX) begin
                  r_wr_ptr    <= w_wr_ptr_nxt;
                  r_audio_out <= saturate(round_shift(w_acc_nxt));
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_idx       <= '0;
                  r_state     <= S_OUT;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.coeff_mode  = r_active_mode;
   assign bus.coeff_idx   = r_idx;
   assign bus.audio_out   = r_audio_out;
   assign bus.done        = r_done;
   assign bus.busy        = r_busy;
   assign bus.active_mode = r_active_mode;
   assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_fir_bank_engine.sv
// Scoreboard bench for fir_bank_engine: a direct-form golden model queues each expected
// output as a sample is driven; every done pops and compares it.
module tb_fir_bank_engine;
   localparam int DATA_W    = 8;
   localparam int COEFF_W   = 10;
   localparam int TAPS      = 31;
   localparam int NUM_MODES = 4;
   localparam int MODE_W    = 2;
   localparam int ACC_W     = 24;
   localparam int OUT_SHIFT = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fir_bank_engine_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAPS(TAPS), .MODE_W(MODE_W)) bus ();

   fir_bank_engine #(
      .DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAPS(TAPS), .NUM_MODES(NUM_MODES),
      .MODE_W(MODE_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .CLEAR_ON_SWITCH(1)
   ) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   int n_tests   = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int done_edge = 0;
   logic signed [DATA_W-1:0]  last_out = '0;
   logic signed [DATA_W-1:0]  exp_q [$];
   logic signed [COEFF_W-1:0] coef [NUM_MODES][TAPS];
   logic signed [DATA_W-1:0]  m_hist [TAPS];
   int                        m_wp;
   logic        [MODE_W-1:0]  m_active;

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Coefficient lookup; banks beyond NUM_MODES read as zero.
   always_comb begin
      bus.coeff = '0;
      if (int'(bus.coeff_mode) < NUM_MODES && int'(bus.coeff_idx) < TAPS)
         bus.coeff = coef[bus.coeff_mode][bus.coeff_idx];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // done is registered on edge E and sampled on edge E+1, so record cyc+1.
   always @(posedge clk) begin
      #1;
      if (bus.done === 1'b1) begin
         done_cnt  <= done_cnt + 1;
         done_edge <= cyc + 1;
         last_out  <= bus.audio_out;
         check_eq("done_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check_eq("audio_out", bus.audio_out, exp_q.pop_front());
      end
   end

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) m_hist[i] = '0;
      m_wp     = 0;
      m_active = '0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic signed [DATA_W-1:0] s, input logic [MODE_W-1:0] m,
                             output logic signed [DATA_W-1:0] y, output bit sw);
      longint acc;
      int     j;
      sw       = (m != m_active);
      m_active = m;
      if (sw) for (int i = 0; i < TAPS; i++) m_hist[i] = '0;
      m_hist[m_wp] = s;
      acc = 0;
      for (int i = 0; i < TAPS; i++) begin
         j = (m_wp - i + TAPS) % TAPS;
         acc += longint'(coef[m][i]) * longint'(m_hist[j]);
      end
      m_wp = (m_wp + 1) % TAPS;
      acc  = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
      if (acc > 127)       y = 8'sd127;
      else if (acc < -128) y = -8'sd128;
      else                 y = acc[DATA_W-1:0];
   endtask

   // Called at a falling edge; the sample is taken on the next rising edge k.
   task automatic send(input logic signed [DATA_W-1:0] s, input logic [MODE_W-1:0] m,
                       output int k, output int lat);
      logic signed [DATA_W-1:0] y;
      bit sw;
      model_step(s, m, y, sw);
      exp_q.push_back(y);
      lat          = sw ? 2 * TAPS + 1 : TAPS + 1;
      bus.audio_in = s;
      bus.mode     = m;
      bus.ready    = 1'b1;
      k            = cyc + 1;
      @(negedge clk);
      bus.ready    = 1'b0;
   endtask

   task automatic wait_done(input int start, input int k, input int lat, input string tag);
      int n = 0;
      while (done_cnt == start && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_done_seen"}, done_cnt > start, 1);
      check_eq({tag, "_latency"}, done_edge, k + lat);
   endtask

   task automatic xfer(input logic signed [DATA_W-1:0] s, input logic [MODE_W-1:0] m,
                       input string tag);
      int st, k, lat;
      st = done_cnt;
      send(s, m, k, lat);
      wait_done(st, k, lat, tag);
   endtask

   initial begin
      int st, k, lat, n;
      bus.ready       = 1'b0;
      bus.audio_in    = '0;
      bus.mode        = '0;
      bus.overrun_clr = 1'b0;
      for (int i = 0; i < TAPS; i++) begin
         coef[0][i] = (i == 0) ? 10'sd511 : 10'sd0;
         coef[1][i] = (i == 0) ? 10'sd300 : COEFF_W'($urandom_range(1, 200));
         coef[2][i] = 10'sd511;
         coef[3][i] = COEFF_W'(int'($urandom_range(0, 1023)) - 512);
      end
      model_reset();

      repeat (3) @(negedge clk);
      check_eq("rst_audio_out", bus.audio_out, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_overrun", bus.overrun, 0);
      check_eq("rst_active_mode", bus.active_mode, 0);
      check_eq("rst_coeff_idx", bus.coeff_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Impulse through bank 0
      xfer(8'sd127, 2'd0, "t1");
      check_eq("t1_first_out", last_out, 63);
      for (int i = 0; i < 3; i++) xfer(8'sd0, 2'd0, "t1_tail");
      check_eq("t1_tail_out", last_out, 0);

      // Saturation at both rails with an all-511 bank
      for (int i = 0; i < TAPS; i++) xfer(8'sd127, 2'd2, "t2_pos");
      check_eq("t2_pos_rail", last_out, 127);
      for (int i = 0; i < TAPS; i++) xfer(-8'sd128, 2'd2, "t2_neg");
      check_eq("t2_neg_rail", last_out, -128);

      // Overrun: ready at k+5 is dropped
      st = done_cnt;
      send(8'sd55, 2'd2, k, lat);
      repeat (4) @(negedge clk);
      check_eq("t3_busy", bus.busy, 1);
      bus.ready    = 1'b1;
      bus.audio_in = 8'sd99;
      @(negedge clk);
      bus.ready    = 1'b0;
      check_eq("t3_overrun_set", bus.overrun, 1);
      wait_done(st, k, lat, "t3");
      repeat (5) @(negedge clk);
      check_eq("t3_single_done", done_cnt, st + 1);
      check_eq("t3_sticky", bus.overrun, 1);
      bus.overrun_clr = 1'b1;
      @(negedge clk);
      bus.overrun_clr = 1'b0;
      check_eq("t3_cleared", bus.overrun, 0);
      st = done_cnt;
      send(-8'sd20, 2'd2, k, lat);
      repeat (4) @(negedge clk);
      bus.ready       = 1'b1;
      bus.overrun_clr = 1'b1;
      bus.audio_in    = 8'sd7;
      @(negedge clk);
      bus.ready       = 1'b0;
      bus.overrun_clr = 1'b0;
      check_eq("t3_set_beats_clr", bus.overrun, 1);
      wait_done(st, k, lat, "t3b");
      bus.overrun_clr = 1'b1;
      @(negedge clk);
      bus.overrun_clr = 1'b0;
      check_eq("t3b_cleared", bus.overrun, 0);

      // Mode switch clears history: 127*300 rounds to 37
      for (int i = 0; i < 10; i++) xfer(8'sd100, 2'd0, "t4_fill");
      xfer(8'sd127, 2'd1, "t4_switch");
      check_eq("t4_out", last_out, 37);
      check_eq("t4_active_mode", bus.active_mode, 1);

      // Reset in the middle of MAC aborts the sample
      xfer(8'sd0, 2'd0, "t5_pre");
      st = done_cnt;
      send(8'sd127, 2'd0, k, lat);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (40) @(negedge clk);
      check_eq("t5_no_done", done_cnt, st);
      check_eq("t5_audio_out", bus.audio_out, 0);
      check_eq("t5_busy", bus.busy, 0);
      check_eq("t5_active_mode", bus.active_mode, 0);
      xfer(8'sd127, 2'd0, "t5_impulse");
      check_eq("t5_first_out", last_out, 63);
      for (int i = 0; i < 2; i++) xfer(8'sd0, 2'd0, "t5_tail");

      // Back-to-back: ready in each done cycle, across a write-pointer wrap
      st = done_cnt;
      send(DATA_W'($urandom_range(0, 255)), 2'd3, k, lat);
      for (int s = 0; s < 40; s++) begin
         n = 0;
         while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         check_eq("t6_done_wait", bus.done, 1);
         st = done_cnt;
         send(DATA_W'($urandom_range(0, 255)), 2'd3, k, lat);
      end
      wait_done(st, k, lat, "t6_last");
      check_eq("t6_overrun", bus.overrun, 0);

      repeat (5) @(negedge clk);
      check_eq("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no completion, required completion within time limit");
      $fatal(1);
   end
endmodule
